// File: rtl/cpu_pkg.sv
// Shared types for the CPU control stage: FSM states, opcode/op fields, writeback selects
// and the decoded instruction class.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_ALU       = 3'd5,
        ST_WRITE_REG = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_MOV_IMM = 3'd1,
        CLS_MOV_REG = 3'd2,
        CLS_ADD     = 3'd3,
        CLS_CMP     = 3'd4,
        CLS_AND     = 3'd5,
        CLS_MVN     = 3'd6
    } instr_cls_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: splits the IR into register/shift fields, sign-extends
// the immediates and classifies the instruction. Zero latency, no flow control.
module instr_dec
    import cpu_pkg::*;
#(
    parameter int IR_W = 16
) (
    input  logic [IR_W-1:0] ir_i,
    output logic [1:0]      op_o,
    output logic [2:0]      rn_o,
    output logic [2:0]      rd_o,
    output logic [1:0]      sh_o,
    output logic [2:0]      rm_o,
    output logic [15:0]     sximm5_o,
    output logic [15:0]     sximm8_o,
    output instr_cls_t      cls_o
);

    logic [2:0] opcode;

    assign opcode   = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
    assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

    always_comb begin
        cls_o = CLS_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op_o == OP_MOV_IMM) begin
                cls_o = CLS_MOV_IMM;
            end else if (op_o == OP_MOV_REG) begin
                cls_o = CLS_MOV_REG;
            end
        end else if (opcode == OPC_ALU) begin
            case (op_o)
                OP_ADD:  cls_o = CLS_ADD;
                OP_CMP:  cls_o = CLS_CMP;
                OP_AND:  cls_o = CLS_AND;
                default: cls_o = CLS_MVN;
            endcase
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore FSM sequencing datapath controls; s/load/w handshake in WAIT.
// Build with CPU_ILLEGAL_TRAP_EN to trap illegal encodings in HALT with an err output.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int IR_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [IR_W-1:0] in,
    input  logic            load,
    input  logic            s,
    output logic            w,
    output logic [2:0]      readnum,
    output logic [2:0]      writenum,
    output logic            write,
    output logic [1:0]      vsel,
    output logic            loada,
    output logic            loadb,
    output logic            loadc,
    output logic            loads,
    output logic            asel,
    output logic            bsel,
    output logic [1:0]      shift,
    output logic [1:0]      ALUop,
    output logic [15:0]     sximm8,
    output logic [15:0]     sximm5
`ifdef CPU_ILLEGAL_TRAP_EN
    ,
    output logic            err
`endif
);

    state_t          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;

    logic [1:0]  op;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    instr_cls_t  cls;

    instr_dec #(.IR_W(IR_W)) u_dec (
        .ir_i     (ir_q),
        .op_o     (op),
        .rn_o     (rn),
        .rd_o     (rd),
        .sh_o     (sh),
        .rm_o     (rm),
        .sximm5_o (sximm5),
        .sximm8_o (sximm8),
        .cls_o    (cls)
    );

    assign ir_d = (state_q == ST_WAIT && load) ? in : ir_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = VSEL_C;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state_q)
            ST_WAIT: begin
                w = 1'b1;
                if (s) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (cls)
                    CLS_MOV_IMM:                 state_d = ST_WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN:        state_d = ST_GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:   state_d = ST_GET_A;
`ifdef CPU_ILLEGAL_TRAP_EN
                    default:                     state_d = ST_HALT;
`else
                    default:                     state_d = ST_WAIT;
`endif
                endcase
            end
            ST_WRITE_IMM: begin
                writenum = rn;
                vsel     = VSEL_IMM8;
                write    = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = ST_GET_B;
            end
            ST_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = ST_ALU;
            end
            ST_ALU: begin
                // Single-operand ops pass B through with A masked off.
                shift = sh;
                asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
                ALUop = (cls == CLS_MOV_REG) ? 2'b00 : op;
                if (cls == CLS_CMP) begin
                    loads   = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    loadc   = 1'b1;
                    state_d = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_HALT: begin
`ifdef CPU_ILLEGAL_TRAP_EN
                state_d = ST_HALT;
`else
                state_d = ST_WAIT;
`endif
            end
            default: state_d = ST_WAIT;
        endcase
        // An edge with reset asserted must never commit a datapath write.
        if (!reset_n) begin
            loada = 1'b0;
            loadb = 1'b0;
            loadc = 1'b0;
            loads = 1'b0;
            write = 1'b0;
        end
    end

`ifdef CPU_ILLEGAL_TRAP_EN
    assign err = (state_q == ST_HALT);
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: a reference model queues expected control cycles and
// latencies per started instruction; a negedge monitor pops and compares them.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset_n, load, s;
    logic [15:0] in_w;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;
`ifdef CPU_ILLEGAL_TRAP_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    cpu_controller #(.IR_W(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in_w),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
`ifdef CPU_ILLEGAL_TRAP_EN
        ,
        .err      (err)
`endif
    );

    typedef struct packed {
        logic        la, lb, lc, ls, wr;
        logic [2:0]  rn, wn;
        logic [1:0]  vs;
        logic        as, bs;
        logic [1:0]  sh, op;
        logic [15:0] sx8, sx5;
    } ev_t;

    ev_t         ev_q[$];
    int          lat_q[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [15:0] ir_m;
    int          busy;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic ev_t blank(input logic [15:0] x);
        ev_t e;
        int  v;
        e = '0;
        v = int'(x[7:0]);
        if (v > 127) v -= 256;
        e.sx8 = v[15:0];
        v = int'(x[4:0]);
        if (v > 15) v -= 32;
        e.sx5 = v[15:0];
        return e;
    endfunction

    // Expected control cycles of one instruction, in order, plus its start-to-WAIT latency.
    task automatic push_instr(input logic [15:0] x, output int lat);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        bit         movr, single, cmp;
        ev_t        e;
        opc = x[15:13]; op = x[12:11]; rn = x[10:8]; rd = x[7:5]; sh = x[4:3]; rm = x[2:0];
        if (opc == 3'b110 && op == 2'b10) begin
            e = blank(x); e.wr = 1'b1; e.wn = rn; e.vs = 2'b10;
            ev_q.push_back(e);
            lat = 3;
        end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
            movr   = (opc == 3'b110);
            single = movr || (op == 2'b11);
            cmp    = !movr && (op == 2'b01);
            if (!single) begin
                e = blank(x); e.la = 1'b1; e.rn = rn; ev_q.push_back(e);
            end
            e = blank(x); e.lb = 1'b1; e.rn = rm; ev_q.push_back(e);
            e = blank(x); e.sh = sh; e.as = single; e.op = movr ? 2'b00 : op;
            if (cmp) e.ls = 1'b1; else e.lc = 1'b1;
            ev_q.push_back(e);
            if (!cmp) begin
                e = blank(x); e.wr = 1'b1; e.wn = rd; e.vs = 2'b00; ev_q.push_back(e);
            end
            lat = (cmp || single) ? 5 : 6;
        end else begin
            lat = 2;
        end
        lat_q.push_back(lat);
    endtask

    // Drives one cycle of inputs (called just after a rising edge) and advances the model.
    task automatic cycle(input bit ld, input bit st, input logic [15:0] word);
        int lat;
        load = ld; s = st; in_w = word;
        if (busy == 0) begin
            if (ld) ir_m = word;
            if (st) begin
                push_instr(ir_m, lat);
                busy = lat;
            end
        end
        @(posedge clk); #1;
        if (busy > 0) busy--;
    endtask

    task automatic wait_idle();
        while (busy > 0) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
        load = 1'b0; s = 1'b0;
    endtask

    task automatic issue(input logic [15:0] x);
        wait_idle();
        cycle(1'b1, 1'b1, x);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] x;
        int          k;
        x = 16'($urandom);
`ifdef CPU_ILLEGAL_TRAP_EN
        k = $urandom_range(0, 5);
`else
        k = $urandom_range(0, 6);
`endif
        case (k)
            0: x[15:11] = 5'b11010;
            1: x[15:11] = 5'b11000;
            2, 3, 4, 5: x[15:11] = {3'b101, 2'(k - 2)};
            default: begin
                if (x[15:13] == 3'b101) x[15:13] = 3'b111;
                if (x[15:13] == 3'b110) x[11] = 1'b1;
            end
        endcase
        return x;
    endfunction

    int lowcnt = 0;
    always @(negedge clk) begin
        ev_t act, exp;
        if (mon_en) begin
            act = '{loada, loadb, loadc, loads, write, readnum, writenum, vsel,
                    asel, bsel, shift, ALUop, sximm8, sximm5};
            if (loada || loadb || loadc || loads || write) begin
                tests++;
                if (ev_q.size() == 0) begin
                    fails++;
                    $display("FAIL ev: unexpected control cycle %h, none expected", act);
                end else begin
                    exp = ev_q.pop_front();
                    if (act !== exp) begin
                        fails++;
                        $display("FAIL ev: got %h expected %h", act, exp);
                    end
                end
            end
            if (!w) begin
                lowcnt++;
            end else if (lowcnt > 0) begin
                tests++;
                if (lat_q.size() == 0) begin
                    fails++;
                    $display("FAIL lat: got %0d, no instruction expected", lowcnt + 1);
                end else if (lowcnt + 1 != lat_q[0]) begin
                    fails++;
                    $display("FAIL lat: got %0d expected %0d", lowcnt + 1, lat_q[0]);
                    void'(lat_q.pop_front());
                end else begin
                    void'(lat_q.pop_front());
                end
                lowcnt = 0;
            end
        end
    end

    initial begin
        busy = 0; ir_m = 16'h0;
        reset_n = 1'b0; load = 1'b1; s = 1'b1; in_w = 16'hA148;
        @(posedge clk); @(posedge clk); #1;
        check("rst_w", 32'(w), 32'd1);
        check("rst_en", 32'({loada, loadb, loadc, loads, write}), 32'd0);
        check("rst_ir", {sximm8, sximm5}, 32'd0);

        // ADD interrupted by reset while in its ALU cycle.
        reset_n = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_alu_loadc", 32'(loadc), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_en", 32'({loada, loadb, loadc, loads, write}), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("mid_rst_w", 32'(w), 32'd1);
        check("mid_rst_ir", {sximm8, sximm5}, 32'd0);

        mon_en = 1'b1;
        issue(16'hD0F8);
        issue(16'hA148);
        issue(16'hA900);
        issue(16'hB864);
        cycle(1'b1, 1'b0, 16'hD0FF);
        wait_idle();
        cycle(1'b0, 1'b1, 16'h0000);
`ifndef CPU_ILLEGAL_TRAP_EN
        issue(16'hE000);
`endif
        for (int i = 0; i < 600; i++) begin
            if (busy == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5, 6: cycle(1'b1, 1'b1, rand_instr());
                    7:       cycle(1'b1, 1'b0, rand_instr());
                    8:       cycle(1'b0, 1'b1, 16'($urandom));
                    default: cycle(1'b0, 1'b0, 16'($urandom));
                endcase
            end else begin
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            end
        end
        wait_idle();
        repeat (3) cycle(1'b0, 1'b0, 16'h0);
        check("drain_ev", 32'(ev_q.size()), 32'd0);
        check("drain_lat", 32'(lat_q.size()), 32'd0);
        check("drain_w", 32'(w), 32'd1);

`ifdef CPU_ILLEGAL_TRAP_EN
        mon_en = 1'b0;
        load = 1'b1; s = 1'b1; in_w = 16'hE000;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("halt_err", 32'(err), 32'd1);
        check("halt_w", 32'(w), 32'd0);
        check("halt_en", 32'({loada, loadb, loadc, loads, write}), 32'd0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("halt_rst_err", 32'(err), 32'd0);
        check("halt_rst_w", 32'(w), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
